// File: rtl/mem_access_master.sv
// Burst initiator for a 12-bit-address / 16-bit-data synchronous memory port.
// Sequences read/write strobes, absorbs the 1-cycle read latency and returns read beats.
module mem_access_master #(
    parameter int MEM_DEPTH = 2191
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [11:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_last,
    output logic        done,
    output logic        addr_err,
    output logic [11:0] mem_adress,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_indata,
    input  logic [15:0] mem_outdata
);
    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DRAIN, WR_BEAT} state_t;

    localparam logic [12:0] DEPTH_W = 13'(MEM_DEPTH);

    state_t      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [3:0]  left_q, left_d;
    logic [1:0]  vld_pipe_q, vld_pipe_d;
    logic [1:0]  oor_pipe_q, oor_pipe_d;
    logic [1:0]  last_pipe_q, last_pipe_d;
    logic        req_ready_q, req_ready_d;
    logic        wr_ready_q, wr_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_last_q, rsp_last_d;
    logic        done_q, done_d;
    logic        addr_err_q, addr_err_d;
    logic [11:0] mem_adress_q, mem_adress_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [15:0] mem_indata_q, mem_indata_d;

    logic        rd_issue;
    logic [11:0] rd_issue_addr;
    logic        rd_issue_last;

    function automatic logic in_rng(input logic [11:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        left_d        = left_q;
        addr_err_d    = addr_err_q;
        mem_adress_d  = mem_adress_q;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        mem_indata_d  = mem_indata_q;
        rd_issue      = 1'b0;
        rd_issue_addr = addr_q;
        rd_issue_last = (left_q == 4'd1);

        // Read return path: pipe[0] = beat on the bus, pipe[1] = memory data valid now.
        rsp_valid_d = vld_pipe_q[1];
        rsp_last_d  = vld_pipe_q[1] & last_pipe_q[1];
        rsp_data_d  = (vld_pipe_q[1] && !oor_pipe_q[1]) ? mem_outdata : 16'h0000;
        done_d      = rsp_last_d;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_err_d = 1'b0;
                    left_d     = req_len;
                    if (req_write) begin
                        state_d = WR_BEAT;
                        addr_d  = req_addr;
                    end else begin
                        state_d       = RD_ISSUE;
                        rd_issue      = 1'b1;
                        rd_issue_addr = req_addr;
                        rd_issue_last = (req_len == 4'd0);
                    end
                end
            end
            RD_ISSUE: begin
                if (left_q == 4'd0) begin
                    state_d = RD_DRAIN;
                end else begin
                    rd_issue = 1'b1;
                    left_d   = left_q - 4'd1;
                end
            end
            RD_DRAIN: begin
                if (rsp_last_q) state_d = IDLE;
            end
            WR_BEAT: begin
                if (wr_valid && wr_ready_q) begin
                    mem_adress_d = addr_q;
                    mem_write_d  = in_rng(addr_q);
                    mem_indata_d = wr_data;
                    addr_d       = addr_q + 12'd1;
                    if (!in_rng(addr_q)) addr_err_d = 1'b1;
                    if (left_q == 4'd0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        left_d = left_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Out-of-range read beats keep their slot but never strobe the memory.
        if (rd_issue) begin
            mem_adress_d = rd_issue_addr;
            mem_read_d   = in_rng(rd_issue_addr);
            addr_d       = rd_issue_addr + 12'd1;
            if (!in_rng(rd_issue_addr)) addr_err_d = 1'b1;
        end

        vld_pipe_d  = {vld_pipe_q[0], rd_issue};
        oor_pipe_d  = {oor_pipe_q[0], rd_issue & ~in_rng(rd_issue_addr)};
        last_pipe_d = {last_pipe_q[0], rd_issue & rd_issue_last};
        req_ready_d = (state_d == IDLE);
        wr_ready_d  = (state_d == WR_BEAT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= 12'h000;
            left_q       <= 4'd0;
            vld_pipe_q   <= 2'b00;
            oor_pipe_q   <= 2'b00;
            last_pipe_q  <= 2'b00;
            req_ready_q  <= 1'b0;
            wr_ready_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 16'h0000;
            rsp_last_q   <= 1'b0;
            done_q       <= 1'b0;
            addr_err_q   <= 1'b0;
            mem_adress_q <= 12'h000;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_indata_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            left_q       <= left_d;
            vld_pipe_q   <= vld_pipe_d;
            oor_pipe_q   <= oor_pipe_d;
            last_pipe_q  <= last_pipe_d;
            req_ready_q  <= req_ready_d;
            wr_ready_q   <= wr_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_last_q   <= rsp_last_d;
            done_q       <= done_d;
            addr_err_q   <= addr_err_d;
            mem_adress_q <= mem_adress_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_indata_q <= mem_indata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign wr_ready   = wr_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_last   = rsp_last_q;
    assign done       = done_q;
    assign addr_err   = addr_err_q;
    assign mem_adress = mem_adress_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_indata = mem_indata_q;

endmodule
